// File: rtl/sonic_pkg.sv
// Shared definitions for the ultrasonic ranger: FSM encoding, derived constants
// and the parameter sanity check used at elaboration.
package sonic_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  function automatic int cyc_per_us(input int clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  function automatic int dist_max(input int dist_w);
    return (1 << dist_w) - 1;
  endfunction

  function automatic bit params_ok(input int clk_hz, input int trig_us,
                                   input int period_us, input int timeout_us,
                                   input int us_per_cm, input int stop_cm,
                                   input int go_cm, input int stop_confirm);
    return (clk_hz >= 1_000_000) && (clk_hz % 1_000_000 == 0) &&
           (trig_us > 0) && (timeout_us > 0) && (us_per_cm > 0) &&
           (trig_us + timeout_us < period_us) && (go_cm > stop_cm) &&
           (stop_confirm > 0);
  endfunction

endpackage

// File: rtl/sonic_tick_div.sv
// Free-running divider: o_tick is a one-cycle strobe every DIV clocks.
module sonic_tick_div
  import sonic_pkg::*;
#(
  parameter int DIV = 100
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/sonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo timing in us, cm conversion and
// a confirm/hysteresis obstacle flag.
module sonic_ranger
  import sonic_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int TRIG_US      = 10,
  parameter int PERIOD_US    = 60_000,
  parameter int TIMEOUT_US   = 30_000,
  parameter int US_PER_CM    = 58,
  parameter int DIST_W       = 9,
  parameter int STOP_CM      = 15,
  parameter int GO_CM        = 20,
  parameter int STOP_CONFIRM = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_echo,
  output logic              o_trig,
  output logic [DIST_W-1:0] o_distance_cm,
  output logic              o_dist_valid,
  output logic              o_timeout,
  output logic              o_stop,
  output logic [2:0]        o_state
);

  localparam int CYC_PER_US = cyc_per_us(CLK_HZ);
  localparam int DIST_MAX   = dist_max(DIST_W);
  localparam int WMAX       = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
  localparam int PW         = $clog2(PERIOD_US + 1);
  localparam int WW         = $clog2(WMAX + 1);
  localparam int UW         = $clog2(US_PER_CM + 1);
  localparam int NW         = $clog2(STOP_CONFIRM + 1);

  localparam logic [PW-1:0]     PERIOD_LAST = PW'(PERIOD_US - 1);
  localparam logic [WW-1:0]     TRIG_LAST   = WW'(TRIG_US - 1);
  localparam logic [WW-1:0]     TMO_LAST    = WW'(TIMEOUT_US - 1);
  localparam logic [UW-1:0]     CM_LAST     = UW'(US_PER_CM - 1);
  localparam logic [DIST_W-1:0] DMAX_D      = DIST_W'(DIST_MAX);
  localparam logic [DIST_W-1:0] STOP_D      = DIST_W'(STOP_CM);
  localparam logic [DIST_W-1:0] GO_D        = DIST_W'(GO_CM);
  localparam logic [NW-1:0]     CONF_N      = NW'(STOP_CONFIRM);

  if (!params_ok(CLK_HZ, TRIG_US, PERIOD_US, TIMEOUT_US, US_PER_CM,
                 STOP_CM, GO_CM, STOP_CONFIRM)) begin : g_param_check
    $error("sonic_ranger: inconsistent parameters");
  end

  logic w_tick;
  sonic_tick_div #(.DIV(CYC_PER_US)) u_tick_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (w_tick)
  );

  // Echo is asynchronous: two flops to synchronise, a third for edge detection.
  logic r_sync1, r_sync2, r_sync3;
  logic w_echo_rise, w_echo_fall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_echo;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_echo_rise = r_sync2 & ~r_sync3;
  assign w_echo_fall = ~r_sync2 & r_sync3;

  state_t r_state, w_state_nxt;
  logic [PW-1:0]     r_period_cnt;
  logic [WW-1:0]     r_wait_cnt;
  logic [UW-1:0]     r_us_sub;
  logic [DIST_W-1:0] r_cm_cnt;
  logic [DIST_W-1:0] r_distance;
  logic [NW-1:0]     r_near_cnt;
  logic [NW-1:0]     w_near_inc;
  logic r_first, r_trig, r_dist_valid, r_timeout, r_stop;
  logic w_tmo, w_trig_nxt, w_load_meas, w_load_tmo, w_leave_idle, w_leave_trig;
  logic w_near, w_far;

  assign w_tmo = w_tick && (r_wait_cnt == TMO_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_tick && (r_first || r_period_cnt == PERIOD_LAST)) w_state_nxt = TRIG;
      TRIG:      if (w_tick && r_wait_cnt == TRIG_LAST) w_state_nxt = WAIT_RISE;
      WAIT_RISE: if (w_tmo) w_state_nxt = DONE;
                 else if (w_echo_rise) w_state_nxt = MEASURE;
      MEASURE:   if (w_echo_fall || w_tmo) w_state_nxt = DONE;
      DONE:      w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_trig_nxt   = (w_state_nxt == TRIG);
    w_leave_idle = (r_state == IDLE) && (w_state_nxt == TRIG);
    w_leave_trig = (r_state == TRIG) && (w_state_nxt == WAIT_RISE);
    w_load_meas  = (r_state == MEASURE) && w_echo_fall;
    w_load_tmo   = (r_state inside {WAIT_RISE, MEASURE}) && !w_load_meas && w_tmo;
  end

  // Timing counters; period_cnt is never cleared except on the trigger launch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_period_cnt <= '0;
      r_first      <= 1'b1;
      r_wait_cnt   <= '0;
      r_us_sub     <= '0;
      r_cm_cnt     <= '0;
    end else begin
      if (w_leave_idle) begin
        r_period_cnt <= '0;
        r_first      <= 1'b0;
      end else if (w_tick && r_period_cnt != PERIOD_LAST) begin
        r_period_cnt <= r_period_cnt + PW'(1);
      end

      if (r_state == IDLE || w_leave_trig) begin
        r_wait_cnt <= '0;
      end else if (w_tick && r_state inside {TRIG, WAIT_RISE, MEASURE}) begin
        r_wait_cnt <= r_wait_cnt + WW'(1);
      end

      if (r_state == WAIT_RISE && w_echo_rise) begin
        r_us_sub <= '0;
        r_cm_cnt <= '0;
      end else if (r_state == MEASURE && w_tick) begin
        if (r_us_sub == CM_LAST) begin
          r_us_sub <= '0;
          if (r_cm_cnt != DMAX_D) r_cm_cnt <= r_cm_cnt + DIST_W'(1);
        end else begin
          r_us_sub <= r_us_sub + UW'(1);
        end
      end
    end
  end

  assign w_near     = !r_timeout && (r_distance < STOP_D);
  assign w_far      = r_timeout || (r_distance >= GO_D);
  assign w_near_inc = (r_near_cnt == CONF_N) ? CONF_N : r_near_cnt + NW'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_trig       <= 1'b0;
      r_distance   <= '0;
      r_dist_valid <= 1'b0;
      r_timeout    <= 1'b0;
      r_near_cnt   <= '0;
      r_stop       <= 1'b0;
    end else begin
      r_trig       <= w_trig_nxt;
      r_dist_valid <= w_load_meas | w_load_tmo;
      if (w_load_meas) begin
        r_distance <= r_cm_cnt;
        r_timeout  <= 1'b0;
      end else if (w_load_tmo) begin
        r_distance <= DMAX_D;
        r_timeout  <= 1'b1;
      end
      // Readings between STOP_CM and GO_CM hold stop but break the near streak.
      if (r_state == DONE) begin
        if (w_near) begin
          r_near_cnt <= w_near_inc;
          if (w_near_inc == CONF_N) r_stop <= 1'b1;
        end else begin
          r_near_cnt <= '0;
          if (w_far) r_stop <= 1'b0;
        end
      end
    end
  end

  assign o_trig        = r_trig;
  assign o_distance_cm = r_distance;
  assign o_dist_valid  = r_dist_valid;
  assign o_timeout     = r_timeout;
  assign o_stop        = r_stop;
  assign o_state       = r_state;

endmodule

// File: tb/tb_sonic_ranger.sv
// Directed bench for sonic_ranger with a scaled clock (2 clk per us) and a
// shortened period so every ranging cycle fits in a short run.
module tb_sonic_ranger;

  localparam int CLK_HZ     = 2_000_000;
  localparam int DIV        = 2;
  localparam int TRIG_US    = 10;
  localparam int PERIOD_US  = 1600;
  localparam int TIMEOUT_US = 1400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       echo = 1'b0;
  logic       o_trig, o_dist_valid, o_timeout, o_stop;
  logic [8:0] o_distance_cm;
  logic [2:0] o_state;

  sonic_ranger #(
    .CLK_HZ(CLK_HZ), .TRIG_US(TRIG_US), .PERIOD_US(PERIOD_US),
    .TIMEOUT_US(TIMEOUT_US), .US_PER_CM(58), .DIST_W(9),
    .STOP_CM(15), .GO_CM(20), .STOP_CONFIRM(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_echo(echo),
    .o_trig(o_trig), .o_distance_cm(o_distance_cm), .o_dist_valid(o_dist_valid),
    .o_timeout(o_timeout), .o_stop(o_stop), .o_state(o_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // scoreboard: {timeout, distance} expected per measurement
  logic [9:0] exp_q[$];
  logic [9:0] exp_v;
  logic       trig_q = 1'b0;
  bit         have_rise = 1'b0;
  int         rise_cyc = 0, last_width = 0, last_period = 0;
  int         n_fall = 0, n_valid = 0;

  always @(negedge clk) begin
    if (rst) begin
      trig_q      = 1'b0;
      have_rise   = 1'b0;
      last_period = 0;
    end else begin
      if (o_trig && !trig_q) begin
        if (have_rise) last_period = cyc - rise_cyc;
        rise_cyc  = cyc;
        have_rise = 1'b1;
      end
      if (!o_trig && trig_q) begin
        last_width = cyc - rise_cyc;
        n_fall++;
      end
      trig_q = o_trig;
      if (o_dist_valid) begin
        n_valid++;
        check_eq("exp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          check_eq("distance_cm", o_distance_cm, exp_v[8:0]);
          check_eq("timeout", o_timeout, exp_v[9]);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_fall();
    int start;
    bit seen;
    start = n_fall;
    seen  = 1'b0;
    for (int i = 0; i < (PERIOD_US + TRIG_US) * DIV + 100; i++) begin
      @(posedge clk);
      if (n_fall != start) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("trig_fall_seen", seen, 1);
  endtask

  task automatic wait_valid(input int v0);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < (TIMEOUT_US + 50) * DIV; i++) begin
      @(posedge clk);
      if (n_valid != v0) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("dist_valid_seen", seen, 1);
  endtask

  // Echo pulses are one clock longer than w_us so the tick count inside the
  // pulse does not depend on divider phase.
  task automatic meas(input int dly_us, input int w_us, input logic [9:0] exp,
                      input bit chk_period, input bit exp_stop);
    int v0;
    wait_fall();
    if (chk_period) check_eq("trig_period", last_period, PERIOD_US * DIV);
    check_eq("trig_width", last_width, TRIG_US * DIV);
    v0 = n_valid;
    exp_q.push_back(exp);
    if (w_us > 0) begin
      repeat (dly_us * DIV) @(posedge clk);
      echo = 1'b1;
      repeat (w_us * DIV + 1) @(posedge clk);
      echo = 1'b0;
    end
    wait_valid(v0);
    @(negedge clk);
    check_eq("stop", o_stop, exp_stop);
    check_eq("one_valid_pulse", n_valid - v0, 1);
  endtask

  localparam logic [9:0] CM10 = {1'b0, 9'd10};
  localparam logic [9:0] CM17 = {1'b0, 9'd17};
  localparam logic [9:0] CM22 = {1'b0, 9'd22};
  localparam logic [9:0] TMO  = {1'b1, 9'd511};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_trig", o_trig, 0);
    check_eq("rst_distance", o_distance_cm, 0);
    check_eq("rst_valid", o_dist_valid, 0);
    check_eq("rst_timeout", o_timeout, 0);
    check_eq("rst_stop", o_stop, 0);
    check_eq("rst_state", o_state, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1 check_eq("first_tick_trig0", o_trig, 0);
    @(posedge clk); #1 check_eq("first_tick_trig1", o_trig, 1);

    // single near reading, then confirm, then release
    meas(100, 580, CM10, 1'b0, 1'b0);
    meas(100, 580, CM10, 1'b1, 1'b1);
    meas(100, 1276, CM22, 1'b1, 1'b0);

    // hysteresis band breaks the near streak
    meas(100, 580, CM10, 1'b1, 1'b0);
    meas(100, 986, CM17, 1'b1, 1'b0);
    meas(100, 580, CM10, 1'b1, 1'b0);

    // no echo at all
    meas(0, 0, TMO, 1'b1, 1'b0);

    // build stop=1, then reset in the middle of a measurement
    meas(100, 580, CM10, 1'b1, 1'b0);
    meas(100, 580, CM10, 1'b1, 1'b1);
    wait_fall();
    repeat (100 * DIV) @(posedge clk);
    echo = 1'b1;
    repeat (200 * DIV) @(posedge clk);
    @(negedge clk);
    check_eq("mid_state_measure", o_state, 3);
    check_eq("mid_stop_before_rst", o_stop, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_trig", o_trig, 0);
    check_eq("abort_stop", o_stop, 0);
    check_eq("abort_valid", o_dist_valid, 0);
    check_eq("abort_distance", o_distance_cm, 0);
    echo = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1 check_eq("rerun_trig0", o_trig, 0);
    @(posedge clk); #1 check_eq("rerun_trig1", o_trig, 1);
    meas(100, 580, CM10, 1'b0, 1'b0);

    // echo stuck high from reset: every cycle times out, period unchanged
    @(negedge clk);
    echo = 1'b1;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    meas(0, 0, TMO, 1'b0, 1'b0);
    meas(0, 0, TMO, 1'b1, 1'b0);

    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (95_000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d limit=%0d", cyc, 95_000);
    $fatal(1, "watchdog");
  end

endmodule
